// File: rtl/cam_axis_packer.sv
// cam_axis_packer: packs PPC camera pixels per AXI4-Stream beat through a beat FIFO.
// Ports:
//   pclk, resetn              clock, asynchronous active-low reset
//   FV, LV, D_IN              parallel camera bus (pixel valid when FV&LV)
//   m_axis_tdata/tvalid/tready/tuser/tlast
//                             packed beat stream, pixel 0 in LSBs, tuser on the
//                             first beat of a frame, tlast on the last beat of a line
//   overflow                  sticky, a beat was dropped on a full FIFO
//   frame_cnt                 completed frames, wrapping
// Optional (CAM_AXIS_LINE_CHECK_EN): parameter LINE_PIX, outputs line_err, line_cnt.
module cam_axis_packer #(
    parameter int PIX_W      = 16,
    parameter int PPC        = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
`ifdef CAM_AXIS_LINE_CHECK_EN
    ,
    parameter int LINE_PIX   = 640
`endif
) (
    input  logic                 pclk,
    input  logic                 resetn,
    input  logic                 FV,
    input  logic                 LV,
    input  logic [PIX_W-1:0]     D_IN,
    output logic [PIX_W*PPC-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frame_cnt
`ifdef CAM_AXIS_LINE_CHECK_EN
    ,
    output logic                 line_err,
    output logic [15:0]          line_cnt
`endif
);
    localparam int DW = PIX_W * PPC;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (PPC > 1) ? $clog2(PPC) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_FV, FRAME} state_t;

    state_t                     state;
    logic [PPC-1:0][PIX_W-1:0]  pack_reg, pack_nxt;
    logic [IW-1:0]              pack_idx;
    logic [DW-1:0]              hold_reg, wr_data;
    logic                       hold_valid, flush_pend, line_act, sof_pending;
    logic                       acc, line_end, wr_en, wr_last, push, pop, full, empty;
    logic [AW:0]                wr_ptr, rd_ptr;
    logic [DW+1:0]              mem [FIFO_DEPTH];

    assign acc      = state == FRAME && FV && LV;
    // line_act is last cycle's acc, so a line ends on the first cycle FV&LV drops
    assign line_end = line_act && !acc;

    // A held beat is only committed once the line is known to continue or end;
    // a partial beat at line end goes straight out if nothing is held, else it
    // is parked in the hold register and flushed on the following cycle.
    always_comb begin
        pack_nxt           = pack_reg;
        pack_nxt[pack_idx] = D_IN;
        wr_en   = flush_pend || (hold_valid && (acc || line_end)) || (line_end && pack_idx != '0);
        wr_data = hold_valid ? hold_reg : pack_reg;
        wr_last = flush_pend || (line_end && !(hold_valid && pack_idx != '0));
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pack_reg    <= '0;
            pack_idx    <= '0;
            hold_reg    <= '0;
            hold_valid  <= 1'b0;
            flush_pend  <= 1'b0;
            line_act    <= 1'b0;
            sof_pending <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_act   <= acc;
            flush_pend <= 1'b0;
            if (wr_en) sof_pending <= 1'b0;
            if (flush_pend) hold_valid <= 1'b0;
            if (acc) begin
                hold_valid <= pack_idx == IW'(PPC - 1);
                if (pack_idx == IW'(PPC - 1)) begin
                    hold_reg <= pack_nxt;
                    pack_reg <= '0;
                    pack_idx <= '0;
                end else begin
                    pack_reg <= pack_nxt;
                    pack_idx <= pack_idx + 1'b1;
                end
            end
            if (line_end) begin
                pack_reg <= '0;
                pack_idx <= '0;
                if (hold_valid && pack_idx != '0) begin
                    hold_reg   <= pack_reg;
                    flush_pend <= 1'b1;
                end else begin
                    hold_valid <= 1'b0;
                end
            end
            case (state)
                IDLE:    if (!FV) state <= WAIT_FV;
                WAIT_FV: if (FV) begin
                    state       <= FRAME;
                    sof_pending <= 1'b1;
                end
                FRAME:   if (!FV) begin
                    state     <= WAIT_FV;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty         = wr_ptr == rd_ptr;
    assign full          = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign m_axis_tvalid = !empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = wr_en && (!full || pop);
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sof_pending, wr_last, wr_data};
    end

`ifdef CAM_AXIS_LINE_CHECK_EN
    logic [15:0] pix_cnt;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_err <= 1'b0;
        end else begin
            if (acc) pix_cnt <= pix_cnt + 1'b1;
            if (line_end) begin
                pix_cnt  <= '0;
                line_cnt <= line_cnt + 1'b1;
                if (pix_cnt != 16'(LINE_PIX)) line_err <= 1'b1;
            end
            if (state == WAIT_FV && FV) line_cnt <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_cam_axis_packer.sv
// tb_cam_axis_packer: directed and random frames against a beat-queue reference model.
module tb_cam_axis_packer;
    localparam int PIX_W = 16;
    localparam int PPC   = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = 2;
    localparam int DW    = PIX_W * PPC;

    logic             pclk = 1'b0, resetn = 1'b0, FV = 1'b0, LV = 1'b0, tready = 1'b1;
    logic [PIX_W-1:0] D_IN = '0;
    logic [DW-1:0]    tdata;
    logic             tvalid, tuser, tlast, overflow;
    logic [CNT_W-1:0] frame_cnt;
`ifdef CAM_AXIS_LINE_CHECK_EN
    logic             line_err;
    logic [15:0]      line_cnt;
`endif

    cam_axis_packer #(
        .PIX_W(PIX_W), .PPC(PPC), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
`ifdef CAM_AXIS_LINE_CHECK_EN
        , .LINE_PIX(4)
`endif
    ) dut (
        .pclk(pclk), .resetn(resetn), .FV(FV), .LV(LV), .D_IN(D_IN),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast), .overflow(overflow), .frame_cnt(frame_cnt)
`ifdef CAM_AXIS_LINE_CHECK_EN
        , .line_err(line_err), .line_cnt(line_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    int            n_cmp = 0, n_bad = 0, exp_frames = 0;
    logic [DW+1:0] exp_q[$];
    logic          sof = 1'b0, arm = 1'b0, seen_low = 1'b1, rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every beat accepted downstream must be the next one the model predicted
    always @(negedge pclk) begin
        logic [DW+1:0] e;
        if (resetn && tvalid && tready) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            chk("beat", {tuser, tlast, tdata}, e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
            if (rnd_ready) tready = ($urandom_range(3) != 0);
        end
    endtask

    // a line becomes ceil(n/PPC) beats, last one zero-padded and marked tlast
    function automatic void model_line(input logic [PIX_W-1:0] px[$]);
        int nb;
        logic [DW-1:0] d;
        nb = (px.size() + PPC - 1) / PPC;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int k = 0; k < PPC; k++)
                if (b * PPC + k < px.size()) d[k*PIX_W +: PIX_W] = px[b*PPC + k];
            if (arm) begin
                exp_q.push_back({sof, b == nb - 1, d});
                sof = 1'b0;
            end
        end
    endfunction

    task automatic drive_line(input logic [PIX_W-1:0] px[$], input bit mdl, input bit cut);
        if (mdl) model_line(px);
        LV = 1'b1;
        foreach (px[i]) begin
            D_IN = px[i];
            cyc(1);
        end
        D_IN = '0;
        if (cut) begin
            FV = 1'b0;
            cyc(1);
        end
        LV = 1'b0;
        cyc(3);
    endtask

    task automatic ramp_line(input int n, input logic [PIX_W-1:0] base, input bit mdl);
        logic [PIX_W-1:0] px[$];
        for (int i = 0; i < n; i++) px.push_back(base + PIX_W'(i));
        drive_line(px, mdl, 1'b0);
    endtask

    task automatic frame_start();
        arm = seen_low;
        sof = 1'b1;
        FV  = 1'b1;
        cyc(2);
    endtask

    task automatic frame_end();
        FV = 1'b0;
        if (arm) exp_frames++;
        seen_low = 1'b1;
        cyc(2);
        chk("frame_cnt", frame_cnt, exp_frames % (1 << CNT_W));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [PIX_W-1:0] px[$];
        cyc(2);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        resetn = 1'b1;
        cyc(3);

        frame_start();
        ramp_line(4, 16'h0001, 1'b1);
        ramp_line(4, 16'h0001, 1'b1);
        frame_end();
        drain();

        frame_start();
        px.delete();
        px.push_back(16'h00A1);
        px.push_back(16'h00A2);
        px.push_back(16'h00A3);
        model_line(px);
        LV = 1'b1;
        D_IN = 16'h00A1;
        cyc(1);
        D_IN = 16'h00A2;
        cyc(1);
        @(negedge pclk);
        chk("lat_early", tvalid, 0);
        D_IN = 16'h00A3;
        cyc(1);
        @(negedge pclk);
        chk("lat_ppc_plus1", tvalid, 1);
        LV = 1'b0;
        D_IN = '0;
        cyc(3);
        frame_end();
        drain();

        tready = 1'b0;
        frame_start();
        ramp_line(16, 16'h0001, 1'b1);
        chk("full_no_ovf", overflow, 0);
        px.delete();
        for (int i = 1; i <= 5; i++) px.push_back(16'h0100 + 16'(i));
        model_line(px);
        LV = 1'b1;
        D_IN = px[0];
        cyc(1);
        D_IN = px[1];
        cyc(1);
        D_IN = px[2];
        tready = 1'b1;
        cyc(1);
        D_IN = px[3];
        cyc(1);
        D_IN = px[4];
        cyc(1);
        LV = 1'b0;
        D_IN = '0;
        cyc(3);
        frame_end();
        drain();
        chk("push_pop_full_no_ovf", overflow, 0);

        tready = 1'b0;
        frame_start();
        ramp_line(20, 16'h0001, 1'b0);
        @(negedge pclk);
        chk("bp_overflow", overflow, 1);
        chk("bp_head", {tvalid, tuser, tlast, tdata}, {3'b110, 32'h00020001});
        cyc(4);
        @(negedge pclk);
        chk("bp_head_stable", {tvalid, tuser, tlast, tdata}, {3'b110, 32'h00020001});
        frame_end();
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 0, 1'b0, 16'(2 * i + 2), 16'(2 * i + 1)});
        sof = 1'b0;
        tready = 1'b1;
        drain();
        cyc(2);
        chk("bp_drained", tvalid, 0);
        chk("ovf_sticky", overflow, 1);

        rnd_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int nl;
            nl = 1 + $urandom_range(2);
            frame_start();
            for (int l = 0; l < nl; l++) begin
                int np;
                np = 1 + $urandom_range(11);
                px.delete();
                for (int i = 0; i < np; i++) px.push_back(PIX_W'($urandom));
                drive_line(px, 1'b1, l == nl - 1 && $urandom_range(1) == 1);
            end
            frame_end();
        end
        rnd_ready = 1'b0;
        tready = 1'b1;
        drain();

        tready = 1'b0;
        frame_start();
        ramp_line(6, 16'h0200, 1'b1);
        LV = 1'b1;
        D_IN = 16'h0300;
        cyc(2);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_tuser_tlast", {tuser, tlast}, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        exp_frames = 0;
        sof = 1'b0;
        arm = 1'b0;
        seen_low = 1'b0;
        cyc(2);
        tready = 1'b1;
        resetn = 1'b1;
        cyc(2);
        LV = 1'b0;
        D_IN = '0;
        cyc(3);
        ramp_line(4, 16'h0400, 1'b1);
        chk("ignored_frame_tvalid", tvalid, 0);
        frame_end();

        frame_start();
        ramp_line(4, 16'h0500, 1'b1);
        ramp_line(4, 16'h0510, 1'b1);
`ifdef CAM_AXIS_LINE_CHECK_EN
        chk("line_err_good", line_err, 0);
`endif
        ramp_line(3, 16'h0520, 1'b1);
`ifdef CAM_AXIS_LINE_CHECK_EN
        chk("line_err_short", line_err, 1);
`endif
        frame_end();
`ifdef CAM_AXIS_LINE_CHECK_EN
        chk("line_cnt", line_cnt, 3);
`endif
        drain();
        chk("final_overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
